// File: rtl/period_meter.sv
// period_meter: averages 2**AVG_LOG2 periods of slow async sig_in in clk_fpga cycles, flags idle timeout
//   in:  clk_fpga, rst (sync, active-high), sig_in (async), enable (level)
//   out: period (averaged, held), period_valid (1-cycle strobe), timeout (level until next result/rst)
module period_meter #(
  parameter int CNT_W = 24,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT = 10_000_000
) (
  input  logic             clk_fpga,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout
);
  localparam int KW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int AW = CNT_W + AVG_LOG2;
  localparam logic [KW-1:0] K_LAST = KW'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT - 1);
  typedef enum logic {ARM, MEAS} state_t;
  state_t state, state_n;
  logic s1, s2, s3;
  logic [CNT_W-1:0] cnt, sample;
  logic [AW-1:0] acc, sum;
  logic [KW-1:0] k;
  logic rise, meas, last, to_hit, done, clr;
  always_comb begin
    rise = s2 & ~s3;
    meas = state == MEAS && enable;
    sample = cnt + 1'b1;
    sum = acc + AW'(sample);
    last = k == K_LAST;
    // a rise in the threshold cycle takes the sample instead of timing out
    to_hit = meas && !rise && cnt == CNT_TO;
    done = meas && rise && last;
    clr = !meas || to_hit || done;
    state_n = !enable ? ARM : state == ARM ? (rise ? MEAS : ARM) : (to_hit ? ARM : MEAS);
  end
  always_ff @(posedge clk_fpga)
    if (rst) state <= ARM;
    else state <= state_n;
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      {s1, s2, s3} <= '0;
      cnt <= '0;
      acc <= '0;
      k <= '0;
      period <= '0;
      period_valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      {s1, s2, s3} <= {sig_in, s1, s2};
      // the edge closing one period also opens the next, so cnt restarts on every rise
      cnt <= (clr || rise) ? '0 : cnt + 1'b1;
      acc <= clr ? '0 : rise ? sum : acc;
      k <= (clr || AVG_LOG2 == 0) ? '0 : rise ? k + 1'b1 : k;
      period <= done ? CNT_W'(sum >> AVG_LOG2) : period;
      period_valid <= done;
      timeout <= done ? 1'b0 : to_hit ? 1'b1 : timeout;
    end
  end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: table-driven, hand-sequenced and randomized checks of period_meter against an event-level model
module tb_period_meter;
  localparam int CNT_W = 16;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT = 300;
  localparam int NAVG = 1 << AVG_LOG2;
  logic clk_fpga = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic enable = 1'b0;
  logic [CNT_W-1:0] period;
  logic period_valid, timeout;
  int vectors = 0;
  int errs = 0;
  int nstrobe = 0;
  bit mon_on = 0;
  logic prev_pv = 1'b0;
  period_meter #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk_fpga(clk_fpga), .rst(rst), .sig_in(sig_in), .enable(enable),
    .period(period), .period_valid(period_valid), .timeout(timeout)
  );
  always #5 clk_fpga = ~clk_fpga;
  // reference model: works on timestamps of detected rising edges
  // (an input edge is seen 3 clocks after it is sampled), averaging
  // gaps between consecutive rises in groups of NAVG
  logic [2:0] hx = '0;
  int cyc = 0, last_rise = 0, nsamp = 0, msum = 0;
  bit armed = 0, mrise;
  logic [CNT_W-1:0] m_period = '0;
  logic m_pv = 1'b0, m_tmo = 1'b0;
  always @(posedge clk_fpga) begin
    if (rst) begin
      hx = '0;
      armed = 0;
      nsamp = 0;
      msum = 0;
      m_period = '0;
      m_pv = 1'b0;
      m_tmo = 1'b0;
    end else begin
      mrise = hx[1] && !hx[2];
      m_pv = 1'b0;
      if (!enable) armed = 0;
      else if (mrise) begin
        if (!armed) begin
          armed = 1;
          nsamp = 0;
          msum = 0;
        end else begin
          msum += cyc - last_rise;
          nsamp++;
          if (nsamp == NAVG) begin
            m_period = CNT_W'(msum / NAVG);
            m_pv = 1'b1;
            m_tmo = 1'b0;
            nsamp = 0;
            msum = 0;
          end
        end
        last_rise = cyc;
      end else if (armed && cyc - last_rise == TIMEOUT) begin
        m_tmo = 1'b1;
        armed = 0;
      end
      hx = {hx[1:0], sig_in};
    end
    cyc++;
  end
  always @(negedge clk_fpga) begin
    if (mon_on) begin
      vectors++;
      if ({period, period_valid, timeout} !== {m_period, m_pv, m_tmo}) begin
        errs++;
        $display("FAIL model t=%0t period %0d want %0d, valid %0b want %0b, timeout %0b want %0b",
                 $time, period, m_period, period_valid, m_pv, timeout, m_tmo);
      end
      if (period_valid === 1'b1) begin
        nstrobe++;
        vectors++;
        if (prev_pv === 1'b1) begin
          errs++;
          $display("FAIL back_to_back t=%0t valid 1 want 0", $time);
        end
      end
      prev_pv = period_valid;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk_fpga);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic period_of(input int p);
    sig_in = 1'b1;
    tick(p / 2);
    sig_in = 1'b0;
    tick(p - p / 2);
  endtask
  task automatic close_rise();
    sig_in = 1'b1;
    tick(3);
    sig_in = 1'b0;
    tick(10);
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask
  typedef struct {
    int p0, p1, p2, p3;
    int exp_period;
    int exp_valid;
    bit exp_tmo;
  } row_t;
  row_t rows[7];
  initial begin
    int n, r, np, p;
    rows[0] = '{100, 104, 102, 106, 103, 1, 1'b0};
    rows[1] = '{99, 99, 99, 99, 99, 1, 1'b0};
    rows[2] = '{2, 2, 2, 2, 2, 1, 1'b0};
    rows[3] = '{2, 3, 2, 3, 2, 1, 1'b0};
    rows[4] = '{7, 8, 9, 10, 8, 1, 1'b0};
    rows[5] = '{300, 300, 300, 300, 300, 1, 1'b0};
    rows[6] = '{301, 301, 301, 301, 0, 0, 1'b1};
    tick(3);
    mon_on = 1;
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rst_pulse();
      enable = 1'b1;
      nstrobe = 0;
      period_of(rows[i].p0);
      period_of(rows[i].p1);
      period_of(rows[i].p2);
      period_of(rows[i].p3);
      close_rise();
      chk($sformatf("row%0d_strobes", i), nstrobe, rows[i].exp_valid);
      chk($sformatf("row%0d_period", i), period, rows[i].exp_period);
      chk($sformatf("row%0d_timeout", i), timeout, rows[i].exp_tmo);
    end
    rst_pulse();
    repeat (4) period_of(50);
    close_rise();
    nstrobe = 0;
    repeat (2) period_of(50);
    n = 0;
    sig_in = 1'b1;
    while (timeout !== 1'b1 && n < 2 * TIMEOUT) begin
      if (n == 2) sig_in = 1'b0;
      tick(1);
      n++;
    end
    chk("stall_delay", n, TIMEOUT + 3);
    chk("stall_strobes", nstrobe, 0);
    chk("stall_period", period, 50);
    repeat (4) period_of(50);
    close_rise();
    chk("resume_timeout", timeout, 0);
    chk("resume_period", period, 50);
    chk("resume_strobes", nstrobe, 1);
    nstrobe = 0;
    repeat (3) period_of(60);
    enable = 1'b0;
    repeat (2) period_of(60);
    chk("en_off_strobes", nstrobe, 0);
    chk("en_off_period", period, 50);
    enable = 1'b1;
    repeat (4) period_of(60);
    close_rise();
    chk("reen_period", period, 60);
    chk("reen_strobes", nstrobe, 1);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    repeat (3) period_of(40);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_period", period, 0);
    chk("midrst_valid", period_valid, 0);
    chk("midrst_timeout", timeout, 0);
    nstrobe = 0;
    repeat (4) period_of(70);
    close_rise();
    chk("midrst_after_period", period, 70);
    chk("midrst_after_strobes", nstrobe, 1);
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) rst_pulse();
      else if (r == 1) begin
        enable = 1'b0;
        tick($urandom_range(1, 20));
        enable = 1'b1;
      end else if (r == 2) tick(TIMEOUT + $urandom_range(0, 20));
      np = $urandom_range(1, 5);
      for (int j = 0; j < np; j++) begin
        p = $urandom_range(2, 320);
        period_of(p);
      end
    end
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of a slow, asynchronous square-wave input (e.g. a divided 1 kHz clock) in cycles of the 100 MHz master clock. This is the inverse of the clock-divider function: it recovers cycle count from a slow clock rather than generating one.
- Averages over 2^AVG_LOG2 consecutive periods and reports the result with a one-cycle valid strobe.
- Flags a timeout when the input stops toggling.
- Used for self-check of slow clocks and for external tick inputs.

Parameters:
- CNT_W, 24, width of the period counter and of the period output.
- AVG_LOG2, 2, log2 of the number of periods averaged per result (default 4 periods).
- TIMEOUT, 10_000_000, cycles without a rising edge before timeout is flagged (100 ms at 100 MHz). Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk_fpga  in  1  100 MHz master clock.
- rst  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous slow input signal.
- enable  in  1  measurement enable (level).
- period  out  CNT_W  averaged period in clk_fpga cycles; holds its last result.
- period_valid  out  1  one-cycle strobe; period is updated on the same cycle.
- timeout  out  1  level; input has been idle for TIMEOUT or more cycles.

Behaviour:
- Synchroniser: sig_in passes through 2 flip-flops (s1, s2), plus a third register s3 for edge detection.
  - rise = s2 & ~s3.
  - rise asserts 3 clk_fpga cycles after the sig_in transition.
  - Only rising edges are used; duty cycle is irrelevant.
- Registers:
  - cnt (CNT_W bits).
  - acc (CNT_W+AVG_LOG2 bits).
  - k (AVG_LOG2 bits; a constant 0 when AVG_LOG2=0).
  - 2-state FSM: ARM, MEAS.
- Reset (rst=1 at a clock edge):
  - state=ARM, cnt=0, acc=0, k=0.
  - period=0, period_valid=0, timeout=0.
  - Synchroniser flops are cleared to 0.
  - rst takes priority over every other event, including mid-measurement.
- ARM:
  - cnt is held at 0.
  - On rise with enable=1: cnt<=0, acc<=0, k<=0, go to MEAS.
  - The first edge only starts the timing; it produces no sample.
- MEAS, rise absent:
  - cnt<=cnt+1.
  - If cnt==TIMEOUT-1: timeout<=1, go to ARM, discard acc/k.
- MEAS, rise present:
  - sample = cnt+1, so edges at cycles t0 and t1 give sample = t1-t0. cnt<=0.
  - If k < 2^AVG_LOG2-1: acc<=acc+sample, k<=k+1.
  - Else:
    - period <= (acc+sample) >> AVG_LOG2 (truncating).
    - period_valid<=1 for exactly one cycle.
    - timeout<=0.
    - acc<=0, k<=0.
    - Stay in MEAS; the closing edge also opens the next period, so there is no re-arm.
- Timeout persistence: timeout stays 1 until the next period_valid or rst. A rise alone does not clear it.
- enable=0 in any state:
  - Next state is ARM; cnt, acc and k are cleared.
  - period and timeout are held.
  - No period_valid is issued.
  - Re-enabling requires a fresh arm edge.
- Simultaneous rise and timeout-threshold in the same cycle: rise wins (the sample is taken, no timeout).
- Overflow: cnt cannot exceed TIMEOUT-1, so sample ≤ TIMEOUT and acc cannot overflow.
- First result latency: arm edge + 2^AVG_LOG2 full periods + 3 synchroniser cycles + 1 output register cycle.
- period_valid is never asserted in two consecutive cycles (the minimum sample is 2, because rise needs s3=0).

Test Plan:
- Steady input: sig_in toggles every 50_001 cycles (period 100_002), enable=1 → first period_valid ≈ 5 × 100_002 cycles after start; period=100_002. Further strobes every 400_008 cycles with the same value; timeout=0.
- Jittered input: periods 100_000, 100_004, 100_002, 100_006 after the arm edge → period=100_003 with one period_valid. A following set of 99_999 ×4 → period=99_999.
- Input stalls low after 2 periods: timeout rises exactly TIMEOUT cycles after the last detected rise; no period_valid; period holds its prior value. When toggling resumes, the first valid result (after arm + 4 periods) clears timeout.
- enable dropped after 3 periods, then raised again: no strobe; the counter restarts from a new arm edge. The next period_valid arrives 4 full periods after re-arm, and period is correct.
- rst pulsed mid-measurement (k=2): all outputs are 0 on the next cycle, state=ARM. The measurement completes correctly after re-arm; no stale acc contribution.
- Fast input with a period of 2 cycles (sig_in toggles every cycle): period=2, strobe every 8 cycles, never on back-to-back cycles.
